// File: rtl/chain_score_max.sv
// Chaining max-reduction: f[i] = max(init_score, max_j(f[j]+score(i,j))), winning predecessor p[i].
// Latency: 2 edges from last candidate accept to out_valid (1 edge on the no_pred path); one candidate per cycle.
// Backpressure: cand_ready only in ACCUM; result held stable in HOLD until out_ready. Optional macro CHAIN_SAT_EN saturates the stage-1 add.
module chain_score_max #(
  parameter int MAX_PRED = 64,
  parameter int IDX_W    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    no_pred,
  input  logic signed [31:0]      init_score,
  input  logic                    cand_valid,
  output logic                    cand_ready,
  input  logic signed [31:0]      cand_score,
  input  logic signed [31:0]      cand_f,
  input  logic [IDX_W-1:0]        cand_idx,
  input  logic                    cand_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [31:0]      out_f,
  output logic [IDX_W-1:0]        out_p,
  output logic                    out_ovf,
  output logic                    busy
);

  // Counter must reach MAX_PRED+1 so the overflow condition stays visible.
  localparam int CNT_W = $clog2(MAX_PRED + 2);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PRED);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_PRED + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t             state;
  logic signed [31:0] best;
  logic [IDX_W-1:0]   best_p;
  logic [CNT_W-1:0]   cnt;
  logic               ovf;

  // Stage-1 register: s1_occ marks an in-flight candidate, s1_valid says it
  // falls inside the predecessor window and may compete for the max.
  logic               s1_occ;
  logic               s1_valid;
  logic signed [31:0] s1_sum;
  logic [IDX_W-1:0]   s1_idx;

  logic               accept;
  logic signed [31:0] add_wrap;
  logic signed [31:0] add_res;

  assign cand_ready = (state == ACCUM);
  assign accept     = cand_valid && cand_ready;
  assign out_valid  = (state == HOLD);
  assign busy       = (state != IDLE);
  assign out_f      = best;
  assign out_p      = best_p;
  assign out_ovf    = ovf;

  assign add_wrap = cand_f + cand_score;

`ifdef CHAIN_SAT_EN
  logic add_ovf;
  // Signed overflow: operands share a sign that the wrapped sum does not.
  assign add_ovf = (cand_f[31] == cand_score[31]) && (add_wrap[31] != cand_f[31]);

  // Clamp the candidate sum to the signed 32-bit range on overflow.
  always_comb begin
    add_res = add_wrap;
    if (add_ovf) begin
      add_res = cand_f[31] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
    end
  end
`else
  assign add_res = add_wrap;
`endif

  // Control FSM plus the two-stage accumulate datapath; one accumulator, so
  // stage 2 always compares against the current best without hazards.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      best     <= '0;
      best_p   <= '1;
      cnt      <= '0;
      ovf      <= 1'b0;
      s1_occ   <= 1'b0;
      s1_valid <= 1'b0;
      s1_sum   <= '0;
      s1_idx   <= '0;
    end else begin
      // Stage 1: register the sum and window membership on accept.
      s1_occ <= accept;
      if (accept) begin
        s1_sum   <= add_res;
        s1_idx   <= cand_idx;
        s1_valid <= (cnt < CNT_MAX);
        if (cnt != CNT_SAT) begin
          cnt <= cnt + 1'b1;
        end
        if (cnt >= CNT_MAX) begin
          ovf <= 1'b1;
        end
      end

      // Stage 2: strict compare keeps the earlier (nearer) candidate on ties.
      if (s1_occ && s1_valid && (s1_sum > best)) begin
        best   <= s1_sum;
        best_p <= s1_idx;
      end

      case (state)
        IDLE: begin
          if (start) begin
            best   <= init_score;
            best_p <= '1;
            cnt    <= '0;
            ovf    <= 1'b0;
            state  <= no_pred ? HOLD : ACCUM;
          end
        end
        ACCUM: begin
          if (accept && cand_last) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          // Last candidate's stage 2 finishes on the edge that clears s1_occ.
          if (!s1_occ) begin
            state <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
